pr_alloc_ctrl: RTL

// Dispatch-side allocation controller for the physical-register freelist. Each cycle it

---
 rtl/pr_alloc_ctrl_pkg.sv | 20 ++
 rtl/pr_alloc_ctrl_if.sv | 35 +++
 rtl/pr_alloc_ctrl_grant.sv | 53 +++++
 rtl/pr_alloc_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/pr_alloc_ctrl_pkg.sv
// Shared definitions for the physical-register allocation controller:
// FSM state encoding, stall-cause codes and a 3-bit popcount helper.
package sys_defs;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } alloc_state_e;

    localparam logic [1:0] STALL_NONE = 2'b00;
    localparam logic [1:0] STALL_FL   = 2'b01;
    localparam logic [1:0] STALL_ROB  = 2'b10;
    localparam logic [1:0] STALL_RS   = 2'b11;

    // Number of set bits in a 3-bit mask (freelist FreeRegValid -> free count).
    function automatic logic [1:0] popcount3(input logic [2:0] mask);
        popcount3 = {1'b0, mask[2]} + {1'b0, mask[1]} + {1'b0, mask[0]};
    endfunction

endpackage

// File: rtl/pr_alloc_ctrl_if.sv
// Dispatch-side allocation bundle: requests and resource status in,
// grants, freelist pop mask, recovery/stall status and counters out.
interface pr_alloc_if #(
    parameter int unsigned CNT_W = 32
);
    import sys_defs::*;

    logic [2:0]       req_valid;
    logic [2:0]       req_has_dest;
    logic [2:0]       fl_valid;
    logic [1:0]       rob_space;
    logic [1:0]       rs_space;
    logic             stall_in;
    logic             bp_recover_en;
    logic [2:0]       dispatch_en;
    logic [2:0]       fl_dispatch_en;
    logic             recover_busy;
    logic [1:0]       stall_cause;
    logic [CNT_W-1:0] fl_stall_cnt;
    logic [CNT_W-1:0] struct_stall_cnt;

    modport master (
        output req_valid, req_has_dest, fl_valid, rob_space, rs_space,
               stall_in, bp_recover_en,
        input  dispatch_en, fl_dispatch_en, recover_busy, stall_cause,
               fl_stall_cnt, struct_stall_cnt
    );

    modport slave (
        input  req_valid, req_has_dest, fl_valid, rob_space, rs_space,
               stall_in, bp_recover_en,
        output dispatch_en, fl_dispatch_en, recover_busy, stall_cause,
               fl_stall_cnt, struct_stall_cnt
    );
endinterface

// File: rtl/pr_alloc_ctrl_grant.sv
// In-order grant logic for the 3 dispatch slots (bit 2 oldest). A slot is
// granted only if every older requesting slot was granted and the freelist,
// ROB and RS can all absorb it; the first refusal blocks all younger slots
// and its reason (freelist > ROB > RS) becomes the stall cause.
module pr_alloc_grant
    import sys_defs::*;
(
    input  logic       i_enable,
    input  logic [2:0] i_req_valid,
    input  logic [2:0] i_req_has_dest,
    input  logic [2:0] i_fl_valid,
    input  logic [1:0] i_rob_space,
    input  logic [1:0] i_rs_space,
    output logic [2:0] o_grant,
    output logic [1:0] o_stall_cause
);

    logic [2:0] w_free;
    logic [2:0] w_dests;
    logic [2:0] w_n;
    logic       w_blocked;

    // Walk slots oldest to youngest, accumulating granted dests and slots.
    always_comb begin
        o_grant       = 3'b000;
        o_stall_cause = STALL_NONE;
        w_blocked     = 1'b0;
        w_dests       = 3'd0;
        w_n           = 3'd0;
        w_free        = {1'b0, popcount3(i_fl_valid)};
        for (int k = 2; k >= 0; k--) begin
            if (i_enable && i_req_valid[k[1:0]] && !w_blocked) begin
                if ((w_dests + {2'b00, i_req_has_dest[k[1:0]]}) > w_free) begin
                    w_blocked     = 1'b1;
                    o_stall_cause = STALL_FL;
                end else if ((w_n + 3'd1) > {1'b0, i_rob_space}) begin
                    w_blocked     = 1'b1;
                    o_stall_cause = STALL_ROB;
                end else if ((w_n + 3'd1) > {1'b0, i_rs_space}) begin
                    w_blocked     = 1'b1;
                    o_stall_cause = STALL_RS;
                end else begin
                    o_grant[k[1:0]] = 1'b1;
                    w_dests         = w_dests + {2'b00, i_req_has_dest[k[1:0]]};
                    w_n             = w_n + 3'd1;
                end
            end else begin
                w_blocked = w_blocked;
            end
        end
    end

endmodule

// File: rtl/pr_alloc_ctrl.sv
// Dispatch allocation controller: recovery FSM (RUN/RECOVER) that blocks
// grants during and shortly after branch recovery, the combinational grant
// path, and saturating stall counters for performance analysis.
module pr_alloc_ctrl
    import sys_defs::*;
#(
    parameter int unsigned WAYS        = 3,
    parameter int unsigned RECOVER_LAT = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic      clock,
    input  logic      reset,
    pr_alloc_if.slave bus
);

    localparam int unsigned REC_W = (RECOVER_LAT < 2) ? 1 : $clog2(RECOVER_LAT + 1);
    localparam logic [REC_W-1:0] REC_LOAD = REC_W'(RECOVER_LAT);

    alloc_state_e     r_state;
    alloc_state_e     w_state_nxt;
    logic [REC_W-1:0] r_rec_cnt;
    logic [REC_W-1:0] w_rec_cnt_nxt;
    logic [WAYS-1:0]  w_grant;
    logic [1:0]       w_stall_cause;
    logic             w_enable;
    logic [CNT_W-1:0] r_fl_stall_cnt;
    logic [CNT_W-1:0] r_struct_stall_cnt;

    // Grants are only allowed out of reset, in RUN, with no backpressure and
    // no recovery this cycle (the freelist ignores pops while recovering).
    assign w_enable = reset && (r_state == RUN) && !bus.stall_in && !bus.bp_recover_en;

    pr_alloc_grant u_grant (
        .i_enable       (w_enable),
        .i_req_valid    (bus.req_valid),
        .i_req_has_dest (bus.req_has_dest),
        .i_fl_valid     (bus.fl_valid),
        .i_rob_space    (bus.rob_space),
        .i_rs_space     (bus.rs_space),
        .o_grant        (w_grant),
        .o_stall_cause  (w_stall_cause)
    );

    assign bus.dispatch_en      = w_grant;
    assign bus.fl_dispatch_en   = w_grant & bus.req_has_dest;
    assign bus.stall_cause      = w_stall_cause;
    assign bus.recover_busy     = reset && ((r_state == RECOVER) || bus.bp_recover_en);
    assign bus.fl_stall_cnt     = r_fl_stall_cnt;
    assign bus.struct_stall_cnt = r_struct_stall_cnt;

    // FSM state and recovery countdown registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_rec_cnt <= {REC_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_rec_cnt <= w_rec_cnt_nxt;
        end
    end

    // Next-state logic: recovery (re)loads the countdown; RECOVER exits to RUN
    // as the countdown goes from 1 to 0.
    always_comb begin
        w_state_nxt   = r_state;
        w_rec_cnt_nxt = r_rec_cnt;
        case (r_state)
            RUN: begin
                if (bus.bp_recover_en && (RECOVER_LAT != 0)) begin
                    w_state_nxt   = RECOVER;
                    w_rec_cnt_nxt = REC_LOAD;
                end else begin
                    w_state_nxt   = RUN;
                    w_rec_cnt_nxt = {REC_W{1'b0}};
                end
            end
            RECOVER: begin
                if (bus.bp_recover_en) begin
                    w_state_nxt   = RECOVER;
                    w_rec_cnt_nxt = REC_LOAD;
                end else if (r_rec_cnt <= REC_W'(1)) begin
                    w_state_nxt   = RUN;
                    w_rec_cnt_nxt = {REC_W{1'b0}};
                end else begin
                    w_state_nxt   = RECOVER;
                    w_rec_cnt_nxt = r_rec_cnt - REC_W'(1);
                end
            end
            default: begin
                w_state_nxt   = RUN;
                w_rec_cnt_nxt = {REC_W{1'b0}};
            end
        endcase
    end

    // Saturating stall counters, one step per stalled cycle by cause.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fl_stall_cnt     <= {CNT_W{1'b0}};
            r_struct_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((w_stall_cause == STALL_FL) && (r_fl_stall_cnt != {CNT_W{1'b1}})) begin
                r_fl_stall_cnt <= r_fl_stall_cnt + CNT_W'(1);
            end else begin
                r_fl_stall_cnt <= r_fl_stall_cnt;
            end
            if (((w_stall_cause == STALL_ROB) || (w_stall_cause == STALL_RS)) &&
                (r_struct_stall_cnt != {CNT_W{1'b1}})) begin
                r_struct_stall_cnt <= r_struct_stall_cnt + CNT_W'(1);
            end else begin
                r_struct_stall_cnt <= r_struct_stall_cnt;
            end
        end
    end

endmodule
